// File: rtl/uart_fifo.sv
// Synchronous single-clock FIFO with registered or show-ahead read port,
// count-decoded status flags and sticky overflow/underflow error flags.
module uart_fifo #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int SHOWAHEAD   = 0,
  parameter int AFULL_LEVEL = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclr,
  input  logic              wrreq,
  input  logic [DATA_W-1:0] data,
  input  logic              rdreq,
  output logic [DATA_W-1:0] q,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   usedw,
  output logic              overflow,
  output logic              underflow
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_W = (ADDR_W + 1)'(AFULL_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_ok;
  logic              rd_ok;

  // Flags come from the registered count only, so they never see same-cycle requests.
  assign empty       = (usedw == '0);
  assign full        = (usedw == DEPTH_W);
  assign almost_full = (usedw >= AFULL_W);

  assign wr_ok = wrreq & ~full;
  assign rd_ok = rdreq & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      usedw     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (sclr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      usedw     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_ok) rd_ptr <= rd_ptr + ADDR_W'(1);
      if (wrreq && full)  overflow  <= 1'b1;
      if (rdreq && empty) underflow <= 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   usedw <= usedw + (ADDR_W + 1)'(1);
        2'b01:   usedw <= usedw - (ADDR_W + 1)'(1);
        default: usedw <= usedw;
      endcase
    end
  end

  // NOTE: the storage array has no reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (wr_ok && !sclr) mem[wr_ptr] <= data;
  end

  if (SHOWAHEAD != 0) begin : g_showahead
    assign q = empty ? '0 : mem[rd_ptr];
  end else begin : g_registered
    logic [DATA_W-1:0] q_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     q_reg <= '0;
      else if (sclr)  q_reg <= '0;
      else if (rd_ok) q_reg <= mem[rd_ptr];
    end

    assign q = q_reg;
  end

endmodule

// File: tb/tb_uart_fifo.sv
// Scoreboard bench for uart_fifo: one registered-read and one show-ahead instance
// share stimulus and are compared against a queue-based model of a 16-word FIFO.
module tb_uart_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclr = 1'b0;
  logic       wrreq = 1'b0;
  logic [7:0] data = '0;
  logic       rdreq = 1'b0;

  logic [7:0] q0, q1;
  logic       empty0, full0, afull0, ovf0, unf0;
  logic       empty1, full1, afull1, ovf1, unf1;
  logic [4:0] usedw0, usedw1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic [7:0] m_q0  = '0;

  always #5 clk = ~clk;

  uart_fifo #(.DATA_W(8), .ADDR_W(4), .SHOWAHEAD(0), .AFULL_LEVEL(12)) dut0 (
    .clk(clk), .rst_n(rst_n), .sclr(sclr), .wrreq(wrreq), .data(data), .rdreq(rdreq),
    .q(q0), .empty(empty0), .full(full0), .almost_full(afull0), .usedw(usedw0),
    .overflow(ovf0), .underflow(unf0)
  );

  uart_fifo #(.DATA_W(8), .ADDR_W(4), .SHOWAHEAD(1), .AFULL_LEVEL(12)) dut1 (
    .clk(clk), .rst_n(rst_n), .sclr(sclr), .wrreq(wrreq), .data(data), .rdreq(rdreq),
    .q(q1), .empty(empty1), .full(full1), .almost_full(afull1), .usedw(usedw1),
    .overflow(ovf1), .underflow(unf1)
  );

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Registered-read monitor: every accepted pop must present the scoreboard head one edge later.
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n && rdreq && !sclr && !empty0) begin
        #1;
        if (exp_q.size() == 0) check("rd_unexpected", 1, 0);
        else                   check("rd_data", q0, exp_q.pop_front());
      end
    end
  end

  task automatic check_state();
    int n = model_q.size();
    check("usedw",       usedw0, n);
    check("empty",       empty0, (n == 0));
    check("full",        full0,  (n == DEPTH));
    check("almost_full", afull0, (n >= 12));
    check("overflow",    ovf0,   m_ovf);
    check("underflow",   unf0,   m_unf);
    check("q_hold",      q0,     m_q0);
    check("sa_usedw",    usedw1, n);
    check("sa_flags",    {empty1, full1, afull1, ovf1, unf1},
          {(n == 0), (n == DEPTH), (n >= 12), m_ovf, m_unf});
    check("sa_q",        q1,     (n == 0) ? 8'h00 : model_q[0]);
  endtask

  // Drive one cycle at the falling edge, advance the model, check after the next edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic s);
    bit wa, ra;
    wrreq = w; data = d; rdreq = r; sclr = s;
    if (s) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_q0  = '0;
    end else begin
      wa = w && (model_q.size() < DEPTH);
      ra = r && (model_q.size() > 0);
      if (w && !wa) m_ovf = 1'b1;
      if (r && !ra) m_unf = 1'b1;
      if (ra) begin
        m_q0 = model_q.pop_front();
        exp_q.push_back(m_q0);
      end
      if (wa) model_q.push_back(d);
    end
    @(posedge clk);
    @(negedge clk);
    wrreq = 1'b0; rdreq = 1'b0; sclr = 1'b0;
    check_state();
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_q0  = '0;
    check("rst_usedw_now", usedw0, 0);
    check("rst_empty_now", {empty0, empty1}, 2'b11);
    check("rst_q_now",     {q0, q1}, 16'h0000);
    check("rst_flags_now", {full0, afull0, ovf0, unf0}, 4'b0000);
    wrreq = 1'b1; rdreq = 1'b1; data = 8'h77;
    @(posedge clk);
    @(negedge clk);
    check("rst_ignores_req", usedw0, 0);
    wrreq = 1'b0; rdreq = 1'b0;
    rst_n = 1'b1;
    check_state();
  endtask

  initial begin
    logic [7:0] cnt;
    @(negedge clk);
    check("reset_state", {usedw0, empty0, full0, afull0, ovf0, unf0}, {5'd0, 5'b10000});
    check("reset_q", {q0, q1}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic ordering through the registered port.
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("basic_empty", empty0, 1);

    // Fill, then write+read while full: write dropped, read accepted.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    check("fill_usedw", usedw0, 16);
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    check("ovf_sticky", ovf0, 1);
    check("ovf_usedw", usedw0, 15);
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("sclr_ovf", ovf0, 0);

    // Read on empty with a concurrent write.
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    check("unf_sticky", unf0, 1);
    check("unf_usedw", usedw0, 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("unf_readback", q0, 8'hA5);

    // Show-ahead first-word latency.
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    check("sa_first", q1, 8'h5A);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("sa_after_pop", {q1, 7'd0, empty1}, 16'h0001);

    // Wrap-around at a steady depth of 8.
    cnt = 8'h00;
    for (int i = 0; i < 8; i++) begin step(1'b1, cnt, 1'b0, 1'b0); cnt++; end
    for (int i = 0; i < 40; i++) begin step(1'b1, cnt, 1'b1, 1'b0); cnt++; end
    check("wrap_usedw", usedw0, 8);

    // Asynchronous reset in the middle of a transfer.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    async_reset();
    step(1'b1, 8'h99, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("post_reset_first", q0, 8'h99);

    // Randomized phases with varying write/read bias and rare clears.
    for (int ph = 0; ph < 16; ph++) begin
      int pw = $urandom_range(10, 90);
      int pr = $urandom_range(10, 90);
      for (int i = 0; i < 50; i++) begin
        step(($urandom_range(99) < pw), 8'($urandom), ($urandom_range(99) < pr),
             ($urandom_range(79) == 0));
      end
    end

    repeat (2) @(negedge clk);
    check("sb_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
